// File: rtl/piso_128bit.sv
// piso_128bit: parallel-in/serial-out transmitter for the AES-128 datapath.
// Captures a WIDTH-bit block in one cycle and shifts it out LSB first, one
// bit per non-stalled cycle, with a bit-valid strobe for the far-end SIPO.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (priority over all inputs)
//   load         capture request; honoured only while ready=1
//   parallel_in  block to transmit, sampled on the accepted load edge
//   hold         stall; freezes shifting while in SHIFT
//   ready        idle and able to accept load
//   serial_out   current bit (shreg[0]) during SHIFT, 0 otherwise
//   serial_valid bit-valid strobe (receiver write enable)
//   done         one-cycle pulse after the last bit has been sent
module piso_128bit #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             hold,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  // Control FSM, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= parallel_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // A held cycle leaves shreg, cnt and state untouched.
          if (!hold) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            if (cnt == LAST_BIT) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decodes; reset forces every output low in the same cycle so an
  // aborted transfer drops serial_valid immediately.
  assign ready        = !reset && (state == IDLE);
  assign serial_out   = !reset && (state == SHIFT) && shreg[0];
  assign serial_valid = !reset && (state == SHIFT) && !hold;
  assign done         = !reset && (state == DONE);

endmodule

// File: tb/tb_piso_128bit.sv
// Directed bench for piso_128bit: reset, loopback into a bench-side SIPO,
// bit order, hold stall, ignored loads, mid-transfer abort and reset/load
// collision.
module tb_piso_128bit;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [127:0] parallel_in;
  logic         hold;
  logic         ready;
  logic         serial_out;
  logic         serial_valid;
  logic         done;

  int vectors    = 0;
  int miscompares = 0;

  // Observations collected by send()
  logic [127:0] sipo;
  int nvalid, first_valid, last_valid, done_cycle, done_count, ready_cycle;
  int ones, hold_so_ones, hold_sv, idle_so_bad, abort_k;
  logic first_bit, abort_sv;

  localparam logic [127:0] JUNK = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  piso_128bit dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .parallel_in  (parallel_in),
    .hold         (hold),
    .ready        (ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Loads word at edge E0 and observes 140 cycles after it (cycle k = E0+k).
  // Inputs change on negedge, outputs are sampled 1 time unit later.
  task automatic send(input logic [127:0] word, input int hold_at, input int hold_len,
                      input bit junk, input int abort_at);
    int v, hu, ac;
    bit junk1, junk2;
    v = 0; hu = 0; ac = 0; junk1 = 0; junk2 = 0;
    sipo = '0; nvalid = 0; first_valid = -1; last_valid = -1; done_cycle = -1;
    done_count = 0; ready_cycle = -1; ones = 0; hold_so_ones = 0; hold_sv = 0;
    idle_so_bad = 0; abort_k = -1; first_bit = 1'b0; abort_sv = 1'b0;
    @(negedge clk);
    parallel_in = word; load = 1'b1; hold = 1'b0; reset = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 140; k++) begin
      load = 1'b0; hold = 1'b0; reset = 1'b0; parallel_in = JUNK;
      if (junk && v == 50 && !junk1) begin load = 1'b1; junk1 = 1; end
      if (junk && v == 128 && done_count == 0 && !junk2) begin load = 1'b1; junk2 = 1; end
      if (hold_len > 0 && v == hold_at && hu < hold_len) begin hold = 1'b1; hu++; end
      if (abort_at >= 0 && v == abort_at && ac < 2) begin
        reset = 1'b1; ac++;
        if (abort_k < 0) abort_k = k;
      end
      #1;
      if (serial_valid) begin
        if (first_valid < 0) begin first_valid = k; first_bit = serial_out; end
        last_valid = k;
        nvalid++;
        sipo = {serial_out, sipo[127:1]};
        ones += int'(serial_out);
        v++;
      end
      if (hold) begin
        hold_so_ones += int'(serial_out);
        hold_sv      += int'(serial_valid);
      end
      if (!serial_valid && !hold && serial_out) idle_so_bad++;
      if (reset && k == abort_k) abort_sv = serial_valid;
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (ready && ready_cycle < 0) ready_cycle = k;
      @(negedge clk);
    end
    load = 1'b0; hold = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; hold = 1'b0; parallel_in = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({ready, serial_valid, serial_out, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got {ready,sv,so,done}=%b expected 0000",
               {ready, serial_valid, serial_out, done});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({ready, serial_valid, serial_out, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_release: got {ready,sv,so,done}=%b expected 1000",
               {ready, serial_valid, serial_out, done});
    end
  endtask

  task automatic test_loopback();
    logic [127:0] w;
    w = 128'h00112233445566778899AABBCCDDEEFF;
    send(w, 0, 0, 1'b0, -1);
    vectors++;
    if (sipo !== w) begin
      miscompares++;
      $display("FAIL loopback_data: got %h expected %h", sipo, w);
    end
    vectors++;
    if (nvalid != 128 || first_valid != 1 || last_valid != 128) begin
      miscompares++;
      $display("FAIL loopback_valid: got count=%0d first=%0d last=%0d expected 128/1/128",
               nvalid, first_valid, last_valid);
    end
    vectors++;
    if (done_cycle != 129 || done_count != 1) begin
      miscompares++;
      $display("FAIL loopback_done: got cycle=%0d pulses=%0d expected 129/1", done_cycle, done_count);
    end
    vectors++;
    if (ready_cycle != 130) begin
      miscompares++;
      $display("FAIL loopback_ready: got cycle %0d expected 130", ready_cycle);
    end
    vectors++;
    if (idle_so_bad != 0) begin
      miscompares++;
      $display("FAIL loopback_so_idle: got %0d cycles with serial_out=1 outside SHIFT expected 0",
               idle_so_bad);
    end
  endtask

  task automatic test_bit_order();
    send(128'h1, 0, 0, 1'b0, -1);
    vectors++;
    if (first_bit !== 1'b1 || ones != 1) begin
      miscompares++;
      $display("FAIL bit_order: got first_bit=%b ones=%0d expected 1/1", first_bit, ones);
    end
  endtask

  task automatic test_hold();
    logic [127:0] w;
    w = '1;
    send(w, 9, 5, 1'b0, -1);
    vectors++;
    if (nvalid != 128 || sipo !== w) begin
      miscompares++;
      $display("FAIL hold_valid: got count=%0d data=%h expected 128/%h", nvalid, sipo, w);
    end
    vectors++;
    if (done_cycle != 134 || ready_cycle != 135) begin
      miscompares++;
      $display("FAIL hold_timing: got done=%0d ready=%0d expected 134/135", done_cycle, ready_cycle);
    end
    vectors++;
    if (hold_so_ones != 5 || hold_sv != 0) begin
      miscompares++;
      $display("FAIL hold_stall: got so_ones=%0d sv=%0d expected 5/0", hold_so_ones, hold_sv);
    end
  endtask

  task automatic test_ignored_load();
    logic [127:0] w;
    w = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    send(w, 0, 0, 1'b1, -1);
    vectors++;
    if (sipo !== w || nvalid != 128) begin
      miscompares++;
      $display("FAIL ignored_load_data: got %h count=%0d expected %h/128", sipo, nvalid, w);
    end
    vectors++;
    if (done_count != 1 || done_cycle != 129 || ready_cycle != 130) begin
      miscompares++;
      $display("FAIL ignored_load_restart: got done=%0d@%0d ready@%0d expected 1@129 ready@130",
               done_count, done_cycle, ready_cycle);
    end
  endtask

  task automatic test_abort();
    logic [127:0] w;
    w = 128'h0123456789ABCDEFFEDCBA9876543210;
    send(w, 0, 0, 1'b0, 64);
    vectors++;
    if (abort_k != 65 || abort_sv !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_valid: got abort_cycle=%0d sv=%b expected 65/0", abort_k, abort_sv);
    end
    vectors++;
    if (done_count != 0 || nvalid != 64) begin
      miscompares++;
      $display("FAIL abort_done: got pulses=%0d bits=%0d expected 0/64", done_count, nvalid);
    end
    vectors++;
    if (ready_cycle != 67) begin
      miscompares++;
      $display("FAIL abort_ready: got cycle %0d expected 67", ready_cycle);
    end
    w = 128'hCAFEF00D_12345678_9ABCDEF0_55AA33CC;
    send(w, 0, 0, 1'b0, -1);
    vectors++;
    if (sipo !== w || done_cycle != 129) begin
      miscompares++;
      $display("FAIL abort_reload: got %h done@%0d expected %h done@129", sipo, done_cycle, w);
    end
  endtask

  task automatic test_reset_load_collision();
    int sv_seen;
    sv_seen = 0;
    @(negedge clk);
    reset = 1'b1; load = 1'b1; parallel_in = JUNK;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      sv_seen += int'(serial_valid);
      if (k == 0) begin
        vectors++;
        if (ready !== 1'b1) begin
          miscompares++;
          $display("FAIL collision_ready: got %b expected 1", ready);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (sv_seen != 0) begin
      miscompares++;
      $display("FAIL collision_capture: got %0d valid cycles expected 0", sv_seen);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_bit_order();
    test_hold();
    test_ignored_load();
    test_abort();
    test_reset_load_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
